// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: DEC->ALU->MEM hazard, forwarding and data-cache freeze control.
// Define FWD_EN for ALU operand forwarding; without it every RAW hazard stalls.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  decValid,
    input  logic [REG_ADDR_W-1:0] decRs1,
    input  logic [REG_ADDR_W-1:0] decRs2,
    input  logic                  decRs1Used,
    input  logic                  decRs2Used,
    input  logic [REG_ADDR_W-1:0] decRd,
    input  logic                  decWriteEnable,
    input  logic                  decLoad,
    input  logic                  branchTaken,
    input  logic                  dataCacheReady,
    output logic                  stallFront,
    output logic                  bubbleDecAlu,
    output logic                  flushDecode,
    output logic                  freezePipe,
    output logic [1:0]            fwdSel1,
    output logic [1:0]            fwdSel2,
    output logic                  memTimeout,
    output logic [CNT_W-1:0]      stallCount
);
    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] alu_rd_q, alu_rd_d, mem_rd_q;
    logic                  alu_we_q, alu_we_d, alu_ld_q, alu_ld_d, mem_we_q, mem_ld_q;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  br, ld_pend, m1a, m2a, m1m, m2m, raw_stall, accept;

    assign br      = branchTaken && !rst;
    assign ld_pend = mem_ld_q && mem_we_q;

    assign m1a = decRs1Used && alu_we_q && alu_rd_q == decRs1 && decRs1 != '0;
    assign m2a = decRs2Used && alu_we_q && alu_rd_q == decRs2 && decRs2 != '0;
    assign m1m = decRs1Used && mem_we_q && mem_rd_q == decRs1 && decRs1 != '0;
    assign m2m = decRs2Used && mem_we_q && mem_rd_q == decRs2 && decRs2 != '0;

`ifdef FWD_EN
    assign raw_stall = decValid && alu_ld_q && (m1a || m2a);
    assign fwdSel1   = (m1a && !alu_ld_q) ? 2'b01 : m1m ? 2'b10 : 2'b00;
    assign fwdSel2   = (m2a && !alu_ld_q) ? 2'b01 : m2m ? 2'b10 : 2'b00;
`else
    assign raw_stall = decValid && (m1a || m2a || m1m || m2m);
    assign fwdSel1   = 2'b00;
    assign fwdSel2   = 2'b00;
`endif

    // A pending load with no data freezes everything; otherwise branch beats load-use/RAW.
    assign freezePipe   = !dataCacheReady && (state_q == MEM_WAIT || ld_pend);
    assign flushDecode  = !freezePipe && br;
    assign bubbleDecAlu = !freezePipe && (br || raw_stall);
    assign stallFront   = freezePipe || (!br && raw_stall);
    assign memTimeout   = timeout_q;
    assign stallCount   = stall_cnt_q;

    assign accept   = decValid && !bubbleDecAlu;
    assign alu_rd_d = accept ? decRd : '0;
    assign alu_we_d = accept && decWriteEnable;
    assign alu_ld_d = accept && decLoad;

    assign state_d     = dataCacheReady ? RUN : (state_q == MEM_WAIT || ld_pend) ? MEM_WAIT : RUN;
    assign wait_d      = (state_q == MEM_WAIT && !dataCacheReady) ? (wait_q == WAIT_MAX ? wait_q : wait_q + 1'b1) : '0;
    assign timeout_d   = timeout_q || wait_d == WAIT_MAX;
    assign stall_cnt_d = (stallFront || freezePipe) && stall_cnt_q != '1 ? stall_cnt_q + 1'b1 : stall_cnt_q;

    // Shadow copy of the destinations in flight; holds while the pipe is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_rd_q <= '0;
            alu_we_q <= 1'b0;
            alu_ld_q <= 1'b0;
            mem_rd_q <= '0;
            mem_we_q <= 1'b0;
            mem_ld_q <= 1'b0;
        end else if (!freezePipe) begin
            alu_rd_q <= alu_rd_d;
            alu_we_q <= alu_we_d;
            alu_ld_q <= alu_ld_d;
            mem_rd_q <= alu_rd_q;
            mem_we_q <= alu_we_q;
            mem_ld_q <= alu_ld_q;
        end
    end

    // Cache-wait state, wait watchdog with sticky timeout, and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized run against a rule-level model.
module tb_pipe_hazard_ctrl;
    localparam int AW = 5;
    localparam int TO = 255;
    localparam int CW = 16;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] rd;
        logic          we;
        logic          ld;
    } ent_t;

    logic          clk = 1'b0, rst = 1'b0;
    logic          decValid = 1'b0, decRs1Used = 1'b0, decRs2Used = 1'b0;
    logic          decWriteEnable = 1'b0, decLoad = 1'b0, branchTaken = 1'b0, dataCacheReady = 1'b1;
    logic [AW-1:0] decRs1 = '0, decRs2 = '0, decRd = '0;
    logic          stallFront, bubbleDecAlu, flushDecode, freezePipe, memTimeout;
    logic [1:0]    fwdSel1, fwdSel2;
    logic [CW-1:0] stallCount;
    int            checks = 0, failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .WAIT_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .decValid(decValid), .decRs1(decRs1), .decRs2(decRs2),
        .decRs1Used(decRs1Used), .decRs2Used(decRs2Used), .decRd(decRd),
        .decWriteEnable(decWriteEnable), .decLoad(decLoad), .branchTaken(branchTaken),
        .dataCacheReady(dataCacheReady), .stallFront(stallFront), .bubbleDecAlu(bubbleDecAlu),
        .flushDecode(flushDecode), .freezePipe(freezePipe), .fwdSel1(fwdSel1), .fwdSel2(fwdSel2),
        .memTimeout(memTimeout), .stallCount(stallCount)
    );

    task automatic clr();
        decValid = 0; decRs1 = '0; decRs2 = '0; decRs1Used = 0; decRs2Used = 0;
        decRd = '0; decWriteEnable = 0; decLoad = 0; branchTaken = 0; dataCacheReady = 1;
    endtask

    task automatic dec(input logic [AW-1:0] rs1, input bit u1, input logic [AW-1:0] rs2, input bit u2,
                       input logic [AW-1:0] rd, input bit we, input bit ld);
        decValid = 1; decRs1 = rs1; decRs1Used = u1; decRs2 = rs2; decRs2Used = u2;
        decRd = rd; decWriteEnable = we; decLoad = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1;
        clr();
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        clr();
        #1 rst = 1;
        @(negedge clk);
        checks++;
        if ({stallFront, bubbleDecAlu, flushDecode, freezePipe, fwdSel1, fwdSel2, memTimeout, stallCount} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%b/%b/%0d/%0d/%b/%0d exp=all zero", stallFront, bubbleDecAlu,
                     flushDecode, freezePipe, fwdSel1, fwdSel2, memTimeout, stallCount);
        end
        rst = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({stallFront, bubbleDecAlu, flushDecode, freezePipe, memTimeout, stallCount} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got stall=%b frz=%b cnt=%0d exp=0", stallFront, freezePipe, stallCount);
        end
        tick();
    endtask

    task automatic test_fwd_alu();
        int n;
        do_reset();
        dec(0, 0, 0, 0, 5, 1, 0);
        @(negedge clk);
        checks++;
        if (stallFront !== 1'b0) begin failures++; $display("FAIL fwd_alu_first got=%b exp=0", stallFront); end
        tick();
        dec(5, 1, 5, 1, 6, 1, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!stallFront) break;
            n += (bubbleDecAlu ? 1 : 0);
            tick();
        end
        checks++;
        if (n != (FWD ? 0 : 2)) begin failures++; $display("FAIL fwd_alu_stalls got=%0d exp=%0d", n, FWD ? 0 : 2); end
        checks++;
        if (fwdSel1 !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("FAIL fwd_alu_sel1 got=%0d exp=%0d", fwdSel1, FWD ? 1 : 0); end
        checks++;
        if (fwdSel2 !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("FAIL fwd_alu_sel2 got=%0d exp=%0d", fwdSel2, FWD ? 1 : 0); end
        checks++;
        if (stallCount !== CW'(FWD ? 0 : 2)) begin failures++; $display("FAIL fwd_alu_cnt got=%0d exp=%0d", stallCount, FWD ? 0 : 2); end
        tick();
        clr();
    endtask

    task automatic test_load_use();
        int n;
        do_reset();
        dec(0, 0, 0, 0, 7, 1, 1);
        tick();
        dec(7, 1, 0, 1, 8, 1, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!stallFront) break;
            n += (bubbleDecAlu ? 1 : 0);
            tick();
        end
        checks++;
        if (n != (FWD ? 1 : 2)) begin failures++; $display("FAIL load_use_stalls got=%0d exp=%0d", n, FWD ? 1 : 2); end
        checks++;
        if (fwdSel1 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL load_use_sel1 got=%0d exp=%0d", fwdSel1, FWD ? 2 : 0); end
        checks++;
        if (fwdSel2 !== 2'd0) begin failures++; $display("FAIL load_use_sel2 got=%0d exp=0", fwdSel2); end
        checks++;
        if (stallCount !== CW'(FWD ? 1 : 2)) begin failures++; $display("FAIL load_use_cnt got=%0d exp=%0d", stallCount, FWD ? 1 : 2); end
        tick();
        clr();
    endtask

    task automatic test_mem_wait();
        int n;
        do_reset();
        dec(0, 0, 0, 0, 7, 1, 1);
        tick();
        clr();
        tick();
        dataCacheReady = 0;
        dec(7, 1, 0, 0, 9, 1, 0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n += (freezePipe && stallFront && !bubbleDecAlu && !flushDecode) ? 1 : 0;
            tick();
        end
        checks++;
        if (n != 4) begin failures++; $display("FAIL mem_wait_frozen got=%0d exp=4", n); end
        dataCacheReady = 1;
        @(negedge clk);
        checks++;
        if (freezePipe !== 1'b0) begin failures++; $display("FAIL mem_wait_release got=%b exp=0", freezePipe); end
        checks++;
        if (stallCount !== CW'(4)) begin failures++; $display("FAIL mem_wait_cnt got=%0d exp=4", stallCount); end
        checks++;
        if (fwdSel1 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL mem_wait_held_sel got=%0d exp=%0d", fwdSel1, FWD ? 2 : 0); end
        checks++;
        if (stallFront !== !FWD) begin failures++; $display("FAIL mem_wait_held_stall got=%b exp=%b", stallFront, !FWD); end
        tick();
        clr();
    endtask

    task automatic test_timeout();
        do_reset();
        dec(0, 0, 0, 0, 7, 1, 1);
        tick();
        clr();
        tick();
        dataCacheReady = 0;
        repeat (200) tick();
        @(negedge clk);
        checks++;
        if (memTimeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", memTimeout); end
        tick();
        repeat (100) tick();
        @(negedge clk);
        checks++;
        if ({memTimeout, freezePipe} !== 2'b11) begin failures++; $display("FAIL timeout_set got=%b%b exp=11", memTimeout, freezePipe); end
        tick();
        dataCacheReady = 1;
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if ({memTimeout, freezePipe} !== 2'b10) begin failures++; $display("FAIL timeout_sticky got=%b%b exp=10", memTimeout, freezePipe); end
        tick();
    endtask

    task automatic test_branch();
        int n;
        do_reset();
        dec(0, 0, 0, 0, 7, 1, 1);
        tick();
        dec(7, 1, 0, 0, 8, 1, 0);
        branchTaken = 1;
        @(negedge clk);
        checks++;
        if ({flushDecode, bubbleDecAlu, stallFront} !== 3'b110) begin
            failures++;
            $display("FAIL branch_over_load_use got=%b%b%b exp=110", flushDecode, bubbleDecAlu, stallFront);
        end
        tick();
        clr();
        @(negedge clk);
        checks++;
        if (stallCount !== '0) begin failures++; $display("FAIL branch_cnt got=%0d exp=0", stallCount); end
        do_reset();
        dec(0, 0, 0, 0, 3, 1, 1);
        tick();
        clr();
        tick();
        dataCacheReady = 0;
        branchTaken = 1;
        dec(3, 1, 0, 0, 4, 1, 0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n += (freezePipe && !flushDecode && !bubbleDecAlu) ? 1 : 0;
            tick();
        end
        checks++;
        if (n != 3) begin failures++; $display("FAIL branch_frozen got=%0d exp=3", n); end
        dataCacheReady = 1;
        @(negedge clk);
        checks++;
        if ({flushDecode, bubbleDecAlu, stallFront, freezePipe} !== 4'b1100) begin
            failures++;
            $display("FAIL branch_after_freeze got=%b%b%b%b exp=1100", flushDecode, bubbleDecAlu, stallFront, freezePipe);
        end
        tick();
        clr();
    endtask

    task automatic test_x0();
        do_reset();
        dec(0, 0, 0, 0, 0, 1, 1);
        tick();
        dec(0, 1, 0, 1, 9, 1, 0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({stallFront, bubbleDecAlu, fwdSel1, fwdSel2} !== 6'b0) begin
                failures++;
                $display("FAIL x0_no_hazard got stall=%b bub=%b f1=%0d f2=%0d exp=0", stallFront, bubbleDecAlu, fwdSel1, fwdSel2);
            end
            tick();
        end
        clr();
    endtask

    task automatic test_async_reset();
        do_reset();
        dec(0, 0, 0, 0, 7, 1, 1);
        tick();
        clr();
        tick();
        dataCacheReady = 0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (freezePipe !== 1'b1) begin failures++; $display("FAIL async_pre_freeze got=%b exp=1", freezePipe); end
        #2 rst = 1;
        #1;
        checks++;
        if ({stallFront, bubbleDecAlu, flushDecode, freezePipe, fwdSel1, fwdSel2, memTimeout, stallCount} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got stall=%b frz=%b cnt=%0d exp=0", stallFront, freezePipe, stallCount);
        end
        @(negedge clk);
        rst = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({freezePipe, stallCount} !== '0) begin failures++; $display("FAIL async_state_run got frz=%b cnt=%0d exp=0", freezePipe, stallCount); end
        tick();
        dataCacheReady = 1;
        dec(0, 0, 0, 0, 7, 1, 1);
        tick();
        clr();
        tick();
        @(negedge clk);
        checks++;
        if (freezePipe !== 1'b0) begin failures++; $display("FAIL async_next_load got=%b exp=0", freezePipe); end
        tick();
    endtask

    task automatic test_random();
        ent_t         alu_e, mem_e;
        bit           h1a, h2a, h1m, h2m, frz, haz, e_stall, e_bub, e_flush, e_to;
        logic [1:0]   e_f1, e_f2;
        int           streak;
        int unsigned  e_cnt;
        do_reset();
        alu_e = '0; mem_e = '0; streak = 0; e_to = 0; e_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            decValid       = $urandom_range(0, 3) != 0;
            decRs1         = AW'($urandom_range(0, 3));
            decRs2         = AW'($urandom_range(0, 3));
            decRs1Used     = $urandom_range(0, 1) == 1;
            decRs2Used     = $urandom_range(0, 1) == 1;
            decRd          = AW'($urandom_range(0, 3));
            decWriteEnable = $urandom_range(0, 3) != 0;
            decLoad        = $urandom_range(0, 2) == 0;
            branchTaken    = $urandom_range(0, 9) == 0;
            dataCacheReady = $urandom_range(0, 4) != 0;
            @(negedge clk);
            h1a = decRs1Used && alu_e.we && alu_e.rd == decRs1 && decRs1 != 0;
            h2a = decRs2Used && alu_e.we && alu_e.rd == decRs2 && decRs2 != 0;
            h1m = decRs1Used && mem_e.we && mem_e.rd == decRs1 && decRs1 != 0;
            h2m = decRs2Used && mem_e.we && mem_e.rd == decRs2 && decRs2 != 0;
            frz = mem_e.ld && mem_e.we && !dataCacheReady;
            haz = FWD ? (decValid && alu_e.ld && (h1a || h2a)) : (decValid && (h1a || h2a || h1m || h2m));
            e_stall = 0; e_bub = 0; e_flush = 0;
            if (frz) e_stall = 1;
            else if (branchTaken) begin e_flush = 1; e_bub = 1; end
            else if (haz) begin e_stall = 1; e_bub = 1; end
            e_f1 = !FWD ? 2'd0 : (h1a && !alu_e.ld) ? 2'd1 : h1m ? 2'd2 : 2'd0;
            e_f2 = !FWD ? 2'd0 : (h2a && !alu_e.ld) ? 2'd1 : h2m ? 2'd2 : 2'd0;
            checks++;
            if ({stallFront, bubbleDecAlu, flushDecode, freezePipe, memTimeout} !== {e_stall, e_bub, e_flush, frz, e_to}) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d got=%b%b%b%b%b exp=%b%b%b%b%b", c, stallFront, bubbleDecAlu, flushDecode,
                         freezePipe, memTimeout, e_stall, e_bub, e_flush, frz, e_to);
            end
            checks++;
            if (stallCount !== CW'(e_cnt)) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, stallCount, e_cnt); end
            if (decValid && !frz) begin
                checks++;
                if ({fwdSel1, fwdSel2} !== {e_f1, e_f2}) begin
                    failures++;
                    $display("FAIL rand_fwd cyc=%0d got=%0d/%0d exp=%0d/%0d", c, fwdSel1, fwdSel2, e_f1, e_f2);
                end
            end
            if ((e_stall || frz) && e_cnt < (2 ** CW) - 1) e_cnt++;
            streak = frz ? streak + 1 : 0;
            if (streak > TO) e_to = 1;
            if (!frz) begin
                mem_e = alu_e;
                alu_e = (decValid && !e_bub) ? ent_t'{decRd, decWriteEnable, decLoad} : ent_t'('0);
            end
            tick();
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_x0();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequences the DEC->ALU->MEM pipeline registers by tracking in-flight destinations.
- Generates stall, bubble and flush controls for the decode/ALU boundary register.
- Generates operand forwarding selects for the ALU.
- Freezes the pipeline while the data cache is busy.
- Sits beside the decoder/control unit; drives enables of every pipeline register.

Parameters:
REG_ADDR_W, 5, register address width
WAIT_TIMEOUT, 255, data-cache wait cycles before memTimeout asserts
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
decValid  in  1  decode stage holds a valid instruction
decRs1  in  REG_ADDR_W  source 1 address
decRs2  in  REG_ADDR_W  source 2 address
decRs1Used  in  1  instruction reads rs1
decRs2Used  in  1  instruction reads rs2
decRd  in  REG_ADDR_W  destination address
decWriteEnable  in  1  instruction writes register
decLoad  in  1  instruction is a load (dataCacheReadEnable)
branchTaken  in  1  ALU-stage branch resolved taken
dataCacheReady  in  1  data cache returns load data this cycle
stallFront  out  1  hold PC and fetch/decode registers
bubbleDecAlu  out  1  load NOP (all enables 0) into DEC->ALU register
flushDecode  out  1  discard decode-stage instruction
freezePipe  out  1  hold every pipeline register including DEC->ALU and ALU->MEM
fwdSel1  out  2  ALU operand 1 source: 00 regfile, 01 ALU-stage result, 10 MEM-stage result
fwdSel2  out  2  same for operand 2
memTimeout  out  1  sticky, wait exceeded WAIT_TIMEOUT
stallCount  out  CNT_W  saturating count of cycles with stallFront or freezePipe

Behaviour:
- Reset (async, rst=1):
  - all outputs 0; state=RUN.
  - shadow entries alu{Rd,We,Ld} and mem{Rd,We,Ld} cleared.
  - wait counter 0.
- Shadow pipeline, updated at posedge when freezePipe=0:
  - alu entry <= decode entry if decValid & !bubbleDecAlu, else zeros.
  - mem entry <= alu entry.
  - When freezePipe=1, both shadow entries hold.
- Register x0 (addr 0) never matches any hazard.
- match1A = decRs1Used & aluWe & aluRd==decRs1 & decRs1!=0. Same form for match1M (mem entry) and for rs2.
- States:
  - RUN: if memLd & memWe & !dataCacheReady, go to MEM_WAIT.
  - MEM_WAIT: if dataCacheReady, go to RUN.
- Combinational outputs, in priority order:
  1. Freeze: freezePipe=stallFront=1 while (state==MEM_WAIT & !dataCacheReady) or (state==RUN & entry condition). No bubble and no flush while frozen; branchTaken is held by its source and is honoured on the first unfrozen cycle.
  2. Flush: branchTaken -> flushDecode=1 and bubbleDecAlu=1, with stallFront=0.
  3. Load-use: decValid & aluLd & (match1A|match2A) -> stallFront=1 and bubbleDecAlu=1 for exactly one cycle. The next cycle the load sits in the mem entry and the operand forwards with select 10.
  4. Forwarding:
     - fwdSel1 = 01 if match1A & !aluLd, else 10 if match1M, else 00. Same rule for fwdSel2.
     - ALU stage has priority over MEM stage.
     - Selects are valid only when freezePipe=0.
- Wait counter:
  - increments each MEM_WAIT cycle; clears on leaving MEM_WAIT.
  - reaching WAIT_TIMEOUT sets memTimeout; memTimeout clears only on rst.
  - counter saturates at WAIT_TIMEOUT.
- stallCount increments each cycle stallFront|freezePipe=1 and saturates at all ones.
- decValid=0 generates no hazard, but the shadow entries still advance (with zeros).

Optional Feature:
FWD_EN
- Defined: forwarding as described.
- Undefined:
  - fwdSel1 and fwdSel2 are tied to 00.
  - Any RAW match against the alu or mem entry (load or not) gives stallFront=1 and bubbleDecAlu=1 each cycle until no match remains (worst case 2 cycles).
  - Freeze and flush priority are unchanged.

Test Plan:
- Reset mid-MEM_WAIT (rst pulse asynchronous to clk) -> all outputs 0 immediately; state RUN; shadows cleared; next load does not freeze.
- ADD x5 then ADD x6,x5,x5 -> second instruction gets fwdSel1=fwdSel2=01, no stall. With FWD_EN undefined -> 2 cycles stallFront=1 and bubbleDecAlu=1.
- LW x7 then ADD x8,x7,x0 -> 1 cycle stallFront=1 and bubbleDecAlu=1, then fwdSel1=10, fwdSel2=00; stallCount=1.
- LW reaches MEM with dataCacheReady=0 for 4 cycles -> freezePipe=1 for 4 cycles; shadows hold; release on ready; stallCount=4. Same stimulus held 300 cycles with WAIT_TIMEOUT=255 -> memTimeout=1 and stays 1.
- branchTaken=1 together with a load-use match -> flushDecode=1, bubbleDecAlu=1, stallFront=0. branchTaken during a freeze -> flush occurs on the first unfrozen cycle.
- Writes to x0 followed by a read of x0 -> fwdSel=00, no stall.
